// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: owns the PC, fetches from instruction memory,
// applies ID-resolved redirects (branch, j, jr), honours stalls and flags illegal PCs.
module fetch_stage #(
    parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
    parameter int unsigned IMEM_WORDS = 1024,
    localparam int unsigned AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic [1:0]    ID_NPCOp,
    input  logic          ID_BranchTaken,
    input  logic [15:0]   ID_imm16,
    input  logic [25:0]   ID_jaddr26,
    input  logic [31:0]   ID_rsValue,
    output logic [AW-1:0] imemAddr,
    input  logic [31:0]   imemData,
    output logic [31:0]   IF_PC,
    output logic [31:0]   ID_PC,
    output logic [31:0]   ID_inst,
    output logic          ID_valid,
    output logic          pcFault,
    output logic [31:0]   fetchCount
);

    localparam logic [31:0] TEXT_BYTES = 32'(4 * IMEM_WORDS);

    logic        redirect;
    logic [31:0] branch_off;
    logic [31:0] target;
    logic [31:0] pc_next;
    logic [31:0] next_off;
    logic        next_bad;

    // Truncated word index; out-of-range PCs are reported through pcFault instead.
    assign imemAddr = AW'((IF_PC - TEXT_BASE) >> 2);

    always_comb begin
        branch_off = {{14{ID_imm16[15]}}, ID_imm16, 2'b00};
        target     = IF_PC + 32'd4;
        case (ID_NPCOp)
            2'b01:   target = ID_PC + 32'd4 + branch_off;
            2'b10:   target = {ID_PC[31:28], ID_jaddr26, 2'b00};
            2'b11:   target = ID_rsValue;
            default: target = IF_PC + 32'd4;
        endcase

        // A squashed bubble in IF/ID never redirects.
        redirect = ID_valid && ((ID_NPCOp == 2'b10) || (ID_NPCOp == 2'b11) ||
                                ((ID_NPCOp == 2'b01) && ID_BranchTaken));
        pc_next  = redirect ? target : IF_PC + 32'd4;
        next_off = pc_next - TEXT_BASE;
        next_bad = (next_off >= TEXT_BYTES) || (pc_next[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            IF_PC      <= TEXT_BASE;
            ID_PC      <= 32'd0;
            ID_inst    <= 32'd0;
            ID_valid   <= 1'b0;
            pcFault    <= 1'b0;
            fetchCount <= 32'd0;
        end else if (!stall) begin
            IF_PC   <= pc_next;
            ID_PC   <= IF_PC;
            pcFault <= pcFault | next_bad;
            if (redirect || pcFault) begin
                ID_inst  <= 32'd0;
                ID_valid <= 1'b0;
            end else begin
                ID_inst    <= imemData;
                ID_valid   <= 1'b1;
                fetchCount <= fetchCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stalls, branch/j/jr redirects and pcFault.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  ID_NPCOp;
    logic        ID_BranchTaken;
    logic [15:0] ID_imm16;
    logic [25:0] ID_jaddr26;
    logic [31:0] ID_rsValue;
    logic [9:0]  imemAddr;
    logic [31:0] imemData;
    logic [31:0] IF_PC;
    logic [31:0] ID_PC;
    logic [31:0] ID_inst;
    logic        ID_valid;
    logic        pcFault;
    logic [31:0] fetchCount;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // imem[i] = i + 1
    assign imemData = 32'(imemAddr) + 32'd1;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .ID_NPCOp      (ID_NPCOp),
        .ID_BranchTaken(ID_BranchTaken),
        .ID_imm16      (ID_imm16),
        .ID_jaddr26    (ID_jaddr26),
        .ID_rsValue    (ID_rsValue),
        .imemAddr      (imemAddr),
        .imemData      (imemData),
        .IF_PC         (IF_PC),
        .ID_PC         (ID_PC),
        .ID_inst       (ID_inst),
        .ID_valid      (ID_valid),
        .pcFault       (pcFault),
        .fetchCount    (fetchCount)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; ID_NPCOp = 2'b00; ID_BranchTaken = 1'b0;
        ID_imm16 = 16'h0; ID_jaddr26 = 26'h0; ID_rsValue = 32'h0;
        step(); step();
        vectors++;
        if (IF_PC !== 32'h3000) begin
            miscompares++; $display("FAIL reset_if_pc got %h want %h", IF_PC, 32'h3000);
        end
        vectors++;
        if ({ID_PC, ID_inst, ID_valid, pcFault} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_id got pc=%h inst=%h v=%b f=%b want all 0",
                     ID_PC, ID_inst, ID_valid, pcFault);
        end
        vectors++;
        if (fetchCount !== 32'd0 || imemAddr !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got cnt=%0d addr=%0d want 0 0", fetchCount, imemAddr);
        end
    endtask

    task automatic test_sequential();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (IF_PC !== 32'h3004 + 32'(4 * i) || ID_PC !== 32'h3000 + 32'(4 * i) ||
                ID_inst !== 32'(i + 1) || ID_valid !== 1'b1 || fetchCount !== 32'(i + 1)) begin
                miscompares++;
                $display("FAIL seq%0d got if=%h id=%h inst=%h v=%b cnt=%0d want %h %h %h 1 %0d",
                         i, IF_PC, ID_PC, ID_inst, ID_valid, fetchCount,
                         32'h3004 + 32'(4 * i), 32'h3000 + 32'(4 * i), i + 1, i + 1);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (IF_PC !== 32'h300C || ID_PC !== 32'h3008 || ID_inst !== 32'd3 ||
                fetchCount !== 32'd3) begin
                miscompares++;
                $display("FAIL stall%0d got if=%h id=%h inst=%h cnt=%0d want 300c 3008 3 3",
                         i, IF_PC, ID_PC, ID_inst, fetchCount);
            end
        end
        stall = 1'b0;
        step();
        vectors++;
        if (IF_PC !== 32'h3010 || ID_PC !== 32'h300C || ID_inst !== 32'd4 ||
            fetchCount !== 32'd4) begin
            miscompares++;
            $display("FAIL stall_resume got if=%h id=%h inst=%h cnt=%0d want 3010 300c 4 4",
                     IF_PC, ID_PC, ID_inst, fetchCount);
        end
    endtask

    task automatic test_branch_taken();
        step();  // ID_PC = 0x3010
        ID_NPCOp = 2'b01; ID_BranchTaken = 1'b1; ID_imm16 = 16'hFFFC;
        step();
        vectors++;
        if (IF_PC !== 32'h3004 || ID_valid !== 1'b0 || ID_inst !== 32'd0 ||
            ID_PC !== 32'h3014 || fetchCount !== 32'd5) begin
            miscompares++;
            $display("FAIL br_taken got if=%h v=%b inst=%h id=%h cnt=%0d want 3004 0 0 3014 5",
                     IF_PC, ID_valid, ID_inst, ID_PC, fetchCount);
        end
        // Branch op still presented but IF/ID is a bubble: must fetch sequentially.
        step();
        vectors++;
        if (IF_PC !== 32'h3008 || ID_PC !== 32'h3004 || ID_inst !== 32'd2 ||
            ID_valid !== 1'b1 || fetchCount !== 32'd6) begin
            miscompares++;
            $display("FAIL br_bubble got if=%h id=%h inst=%h v=%b cnt=%0d want 3008 3004 2 1 6",
                     IF_PC, ID_PC, ID_inst, ID_valid, fetchCount);
        end
        ID_NPCOp = 2'b00; ID_BranchTaken = 1'b0;
    endtask

    task automatic test_branch_not_taken();
        step(); step(); step();  // ID_PC = 0x3010, count 9
        ID_NPCOp = 2'b01; ID_BranchTaken = 1'b0; ID_imm16 = 16'hFFFC;
        step();
        vectors++;
        if (IF_PC !== 32'h3018 || ID_PC !== 32'h3014 || ID_inst !== 32'd6 ||
            ID_valid !== 1'b1 || fetchCount !== 32'd10) begin
            miscompares++;
            $display("FAIL br_not_taken got if=%h id=%h inst=%h v=%b cnt=%0d want 3018 3014 6 1 10",
                     IF_PC, ID_PC, ID_inst, ID_valid, fetchCount);
        end
        ID_NPCOp = 2'b00;
    endtask

    task automatic test_jr_stall();
        ID_NPCOp = 2'b11; ID_rsValue = 32'h3040; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (IF_PC !== 32'h3018 || ID_PC !== 32'h3014 || fetchCount !== 32'd10) begin
                miscompares++;
                $display("FAIL jr_stall%0d got if=%h id=%h cnt=%0d want 3018 3014 10",
                         i, IF_PC, ID_PC, fetchCount);
            end
        end
        stall = 1'b0;
        step();
        vectors++;
        if (IF_PC !== 32'h3040 || ID_valid !== 1'b0 || ID_inst !== 32'd0 ||
            ID_PC !== 32'h3018 || fetchCount !== 32'd10) begin
            miscompares++;
            $display("FAIL jr_redirect got if=%h v=%b inst=%h id=%h cnt=%0d want 3040 0 0 3018 10",
                     IF_PC, ID_valid, ID_inst, ID_PC, fetchCount);
        end
        ID_NPCOp = 2'b00;
        step();
        vectors++;
        if (IF_PC !== 32'h3044 || ID_PC !== 32'h3040 || ID_inst !== 32'd17 ||
            fetchCount !== 32'd11) begin
            miscompares++;
            $display("FAIL jr_target_fetch got if=%h id=%h inst=%h cnt=%0d want 3044 3040 17 11",
                     IF_PC, ID_PC, ID_inst, fetchCount);
        end
    endtask

    task automatic test_jump_fault();
        ID_NPCOp = 2'b10; ID_jaddr26 = 26'h0;
        step();
        vectors++;
        if (IF_PC !== 32'h0 || pcFault !== 1'b1 || ID_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL j_fault got if=%h f=%b v=%b want 0 1 0", IF_PC, pcFault, ID_valid);
        end
        ID_NPCOp = 2'b00;
        step();
        vectors++;
        if (IF_PC !== 32'h4 || pcFault !== 1'b1 || ID_valid !== 1'b0 || ID_inst !== 32'd0 ||
            fetchCount !== 32'd11) begin
            miscompares++;
            $display("FAIL fault_hold got if=%h f=%b v=%b inst=%h cnt=%0d want 4 1 0 0 11",
                     IF_PC, pcFault, ID_valid, ID_inst, fetchCount);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (pcFault !== 1'b0 || IF_PC !== 32'h3000 || ID_valid !== 1'b0 ||
            fetchCount !== 32'd0) begin
            miscompares++;
            $display("FAIL fault_reset got f=%b if=%h v=%b cnt=%0d want 0 3000 0 0",
                     pcFault, IF_PC, ID_valid, fetchCount);
        end
    endtask

    task automatic test_range_edge();
        step();  // ID_PC = 0x3000 valid
        ID_NPCOp = 2'b11; ID_rsValue = 32'h3FFC;
        step();
        vectors++;
        if (IF_PC !== 32'h3FFC || pcFault !== 1'b0 || imemAddr !== 10'h3FF) begin
            miscompares++;
            $display("FAIL edge_last got if=%h f=%b addr=%h want 3ffc 0 3ff",
                     IF_PC, pcFault, imemAddr);
        end
        ID_NPCOp = 2'b00;
        step();
        vectors++;
        if (IF_PC !== 32'h4000 || pcFault !== 1'b1 || ID_inst !== 32'h400 ||
            ID_valid !== 1'b1 || fetchCount !== 32'd2) begin
            miscompares++;
            $display("FAIL edge_over got if=%h f=%b inst=%h v=%b cnt=%0d want 4000 1 400 1 2",
                     IF_PC, pcFault, ID_inst, ID_valid, fetchCount);
        end
        step();
        vectors++;
        if (ID_valid !== 1'b0 || fetchCount !== 32'd2 || IF_PC !== 32'h4004) begin
            miscompares++;
            $display("FAIL edge_squash got v=%b cnt=%0d if=%h want 0 2 4004",
                     ID_valid, fetchCount, IF_PC);
        end
    endtask

    task automatic test_misaligned();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        ID_NPCOp = 2'b11; ID_rsValue = 32'h3002;
        step();
        vectors++;
        if (IF_PC !== 32'h3002 || pcFault !== 1'b1) begin
            miscompares++;
            $display("FAIL misaligned got if=%h f=%b want 3002 1", IF_PC, pcFault);
        end
        ID_NPCOp = 2'b00;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_taken();
        test_branch_not_taken();
        test_jr_stall();
        test_jump_fault();
        test_range_edge();
        test_misaligned();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the 5-stage MIPS pipeline; directly upstream of the ID stage.
- Owns the PC. Drives the instruction-memory word address. Applies next-PC selection resolved in ID (branch, j, jr).
- Honours load-use stalls from the hazard unit. Squashes the wrong-path fetch on redirect. Counts issued instructions for simulation checks.

Parameters:
- TEXT_BASE, 32'h0000_3000, reset PC and base of text segment
- IMEM_WORDS, 1024, instruction memory depth in words; legal PC range is TEXT_BASE .. TEXT_BASE+4*IMEM_WORDS-4

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID register
- ID_NPCOp  in  2  from ID decode: 00 PC+4, 01 branch, 10 j/jal, 11 jr
- ID_BranchTaken  in  1  branch condition true (evaluated in ID on bypassed operands)
- ID_imm16  in  16  branch offset field of the ID instruction
- ID_jaddr26  in  26  jump index field of the ID instruction
- ID_rsValue  in  32  bypass-corrected rs value for jr
- imemAddr  out  log2(IMEM_WORDS)  word index = (IF_PC-TEXT_BASE)>>2
- imemData  in  32  combinational instruction memory read data
- IF_PC  out  32  current fetch PC
- ID_PC  out  32  PC of instruction held in IF/ID
- ID_inst  out  32  instruction held in IF/ID (0 = nop when squashed)
- ID_valid  out  1  IF/ID holds a real instruction
- pcFault  out  1  sticky: PC left the legal text range or was misaligned
- fetchCount  out  32  number of instructions accepted into IF/ID

Behaviour:
- Reset (rst=1 at posedge): IF_PC=TEXT_BASE, ID_PC=0, ID_inst=0, ID_valid=0, pcFault=0, fetchCount=0. Reset overrides stall and redirect, including mid-redirect.
- No branch delay slot. Branch, j and jr resolve in ID; 1-cycle penalty.
- Redirect condition: ID_valid && (ID_NPCOp==10 || ID_NPCOp==11 || (ID_NPCOp==01 && ID_BranchTaken)).
- Redirect targets:
  - Branch: ID_PC+4+({{14{imm16[15]}},imm16,2'b00}).
  - j: {ID_PC[31:28], jaddr26, 2'b00}.
  - jr: ID_rsValue.
  - All arithmetic is 32-bit modulo.
- Per posedge, when not in reset, apply the first matching rule:
  1. stall=1: IF_PC, ID_PC, ID_inst, ID_valid and fetchCount all hold. A redirect is ignored, because ID's operands are not final; it re-evaluates once the stall drops.
  2. Redirect: IF_PC <= target; ID_inst <= 0; ID_valid <= 0; ID_PC <= IF_PC (kept for debug); fetchCount unchanged. This squashes the wrong-path fetch.
  3. Otherwise: IF_PC <= IF_PC+4; ID_inst <= imemData; ID_PC <= IF_PC; ID_valid <= 1; fetchCount += 1.
- A redirect with ID_valid=0 (a squashed bubble) is never taken, whatever ID_NPCOp is.
- pcFault is set when a new IF_PC is outside the legal range or IF_PC[1:0]!=0.
  - Once set, it holds until reset.
  - While pcFault=1, rule 3 loads ID_inst=0 and ID_valid=0 instead of fetching, and fetchCount holds.
  - PC updates still proceed, so a later redirect back into range does not clear the flag.
- imemAddr is combinational from IF_PC. Bits above the index are truncated; an out-of-range PC is covered by pcFault.
- fetchCount wraps at 2^32.

Test Plan:
- Hold rst=1 for 2 cycles, then release with no redirects and imem[i]=i+1 -> IF_PC steps 0x3000, 0x3004, 0x3008. ID_inst=1 with ID_PC=0x3000 on the first cycle after release. fetchCount=3 after 3 cycles.
- Stall for 2 cycles while ID holds 0x3008 -> IF_PC stays 0x300C and ID_PC stays 0x3008. fetchCount is unchanged. The stream resumes with 0x300C's word next.
- Branch at ID_PC=0x3010, NPCOp=01, taken, imm16=0xFFFC -> IF_PC becomes 0x3004. The following cycle has ID_valid=0 and ID_inst=0.
- The same branch with ID_BranchTaken=0 -> sequential fetch and no bubble.
- jr with ID_rsValue=0x3040 while stall=1 -> no redirect. After stall drops, IF_PC becomes 0x3040.
- j to index 0 (target 0x0000_0000) -> pcFault=1 and ID_valid stays 0. After rst, pcFault=0 and IF_PC=0x3000.
